// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one negedge-sampled, word-wide Mem between the IF port (word fetches)
//   and the LS port (byte/half/word loads and stores, with read-modify-write for sub-word stores).
// Ports: sys_clk/sys_rst (sync, active high); if_req/if_addr -> if_ack/if_rdata/if_err;
//   ls_req/ls_we/ls_size/ls_unsigned/ls_addr/ls_wdata -> ls_ack/ls_rdata/ls_err;
//   mem_op/mem_rw/mem_addr/mem_data_w -> Mem, mem_data_r <- Mem; busy = FSM not idle.
// Define MEM_ARB_RR_EN for round-robin arbitration on IF/LS collisions (default: LS over IF).
// Rejected requests spend one ACCESS cycle with mem_op=0 so their ack lands with the same
//   latency as a load.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_err,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [1:0]            ls_size,
  input  logic                  ls_unsigned,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_ack,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  ls_err,
  output logic                  mem_op,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_w,
  input  logic [DATA_WIDTH-1:0] mem_data_r,
  output logic                  busy
);
  typedef enum logic [2:0] {IDLE, ACCESS, RMW_RD, RMW_WR, RESP} state_t;
  state_t state;
  logic cur_ls, cur_we, cur_uns, cur_err;
  logic [1:0] cur_size, cur_lo;
  logic [15:0] cur_wdata;
  logic pick_ls, g_we, g_err;
  logic [1:0] g_size;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [7:0] rd_b;
  logic [15:0] rd_h;
  logic [DATA_WIDTH-1:0] load_val, merged;
`ifdef MEM_ARB_RR_EN
  logic last_grant;
  assign pick_ls = ls_req && !(if_req && last_grant);
  always_ff @(posedge sys_clk)
    last_grant <= sys_rst ? 1'b0 : (state == IDLE && (ls_req || if_req)) ? pick_ls : last_grant;
`else
  assign pick_ls = ls_req;
`endif
  always_comb begin
    g_addr = pick_ls ? ls_addr : if_addr;
    g_size = pick_ls ? ls_size : 2'b10;
    g_we = pick_ls && ls_we;
    g_err = g_size == 2'b11 || (g_size == 2'b01 && g_addr[0]) || (g_size == 2'b10 && g_addr[1:0] != 2'b00);
  end
  assign rd_b = mem_data_r[{cur_lo, 3'b000} +: 8];
  assign rd_h = mem_data_r[{cur_lo[1], 4'b0000} +: 16];
  assign load_val = cur_size == 2'b00 ? {{24{!cur_uns && rd_b[7]}}, rd_b} :
                    cur_size == 2'b01 ? {{16{!cur_uns && rd_h[15]}}, rd_h} : mem_data_r;
  always_comb begin
    merged = mem_data_r;
    if (cur_size == 2'b00) merged[{cur_lo, 3'b000} +: 8] = cur_wdata[7:0];
    else merged[{cur_lo[1], 4'b0000} +: 16] = cur_wdata;
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      busy <= 1'b0;
      if_ack <= 1'b0;
      if_err <= 1'b0;
      if_rdata <= '0;
      ls_ack <= 1'b0;
      ls_err <= 1'b0;
      ls_rdata <= '0;
      mem_op <= 1'b0;
      mem_rw <= 1'b0;
      mem_addr <= '0;
      mem_data_w <= '0;
    end else begin
      case (state)
        IDLE: if (ls_req || if_req) begin
          cur_ls <= pick_ls;
          cur_we <= g_we;
          cur_size <= g_size;
          cur_uns <= ls_unsigned;
          cur_lo <= g_addr[1:0];
          cur_wdata <= ls_wdata[15:0];
          cur_err <= g_err;
          mem_op <= !g_err;
          mem_rw <= !g_err && g_we && g_size == 2'b10;
          mem_addr <= {g_addr[ADDR_WIDTH-1:2], 2'b00};
          mem_data_w <= (g_we && g_size == 2'b10) ? ls_wdata : mem_data_w;
          busy <= 1'b1;
          state <= (g_err || !g_we || g_size == 2'b10) ? ACCESS : RMW_RD;
        end
        ACCESS: begin
          mem_op <= 1'b0;
          mem_rw <= 1'b0;
          ls_ack <= cur_ls;
          ls_err <= cur_ls && cur_err;
          ls_rdata <= (cur_ls && !cur_we && !cur_err) ? load_val : '0;
          if_ack <= !cur_ls;
          if_err <= !cur_ls && cur_err;
          if_rdata <= (!cur_ls && !cur_err) ? mem_data_r : '0;
          state <= RESP;
        end
        RMW_RD: begin
          mem_data_w <= merged;
          mem_rw <= 1'b1;
          state <= RMW_WR;
        end
        RMW_WR: begin
          mem_op <= 1'b0;
          mem_rw <= 1'b0;
          ls_ack <= 1'b1;
          ls_err <= 1'b0;
          ls_rdata <= '0;
          state <= RESP;
        end
        RESP: begin
          if_ack <= 1'b0;
          if_err <= 1'b0;
          if_rdata <= '0;
          ls_ack <= 1'b0;
          ls_err <= 1'b0;
          ls_rdata <= '0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
